// File: rtl/kgp_control_unit.sv
// KGP-RISC multicycle control FSM: sequences IF/ID/EX/MEM/WB and drives datapath strobes.
// Define CTRL_PERF_EN to build the retired-instruction counter behind instret.
module kgp_control_unit #(
    parameter logic [3:0] ADD_FUNC = 4'h0,
    parameter logic [5:0] HALT_OPC = 6'h3F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] ir,
    output logic        readim,
    output logic        ldir,
    output logic        ldnpc,
    output logic        ldA,
    output logic        ldB,
    output logic        ldimm,
    output logic [1:0]  opcond,
    output logic        alusel1,
    output logic        alusel2,
    output logic        aluen,
    output logic        ldaluout,
    output logic [3:0]  alufunc,
    output logic        regwrite,
    output logic        writedmem,
    output logic        readdmem,
    output logic        ldlmd,
    output logic        selwb,
    output logic        branch,
    output logic        ldpc,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT, S_ERR
    } state_t;

    state_t state, state_n;

    logic [5:0] op;
    logic       is_r, is_alui, is_lw, is_sw, is_br, is_bc, is_halt, is_legal;
    logic [1:0] cond;
    logic       ir_unused;

    assign op       = ir[31:26];
    assign cond     = op[1:0];
    assign is_halt  = (op == HALT_OPC);
    assign is_r     = (op == 6'b000000);
    assign is_alui  = (op[5:3] == 3'b001);
    assign is_lw    = (op == 6'b010000);
    assign is_sw    = (op == 6'b010001);
    assign is_br    = (op == 6'b100000);
    assign is_bc    = (op[5:2] == 4'b1000) && (op[1:0] != 2'b00);
    assign is_legal = is_r | is_alui | is_lw | is_sw | is_br | is_bc;
    assign ir_unused = &{1'b0, ir[25:4]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        readim    = 1'b0;
        ldir      = 1'b0;
        ldnpc     = 1'b0;
        ldA       = 1'b0;
        ldB       = 1'b0;
        ldimm     = 1'b0;
        opcond    = 2'b00;
        alusel1   = 1'b0;
        alusel2   = 1'b0;
        aluen     = 1'b0;
        ldaluout  = 1'b0;
        alufunc   = 4'h0;
        regwrite  = 1'b0;
        writedmem = 1'b0;
        readdmem  = 1'b0;
        ldlmd     = 1'b0;
        selwb     = 1'b0;
        branch    = 1'b0;
        ldpc      = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;
        unique case (state)
            S_IDLE: if (run) state_n = S_IF;
            S_IF: begin
                readim  = 1'b1;
                ldir    = 1'b1;
                ldnpc   = 1'b1;
                state_n = S_ID;
            end
            S_ID: begin
                ldA   = 1'b1;
                ldB   = 1'b1;
                ldimm = 1'b1;
                if (is_halt)        state_n = S_HALT;
                else if (!is_legal) state_n = S_ERR;
                else                state_n = S_EX;
            end
            S_EX: begin
                state_n = S_MEM;
                unique case (1'b1)
                    is_r: begin
                        alusel1  = 1'b1;
                        aluen    = 1'b1;
                        ldaluout = 1'b1;
                        alufunc  = ir[3:0];
                    end
                    is_alui: begin
                        alusel1  = 1'b1;
                        alusel2  = 1'b1;
                        aluen    = 1'b1;
                        ldaluout = 1'b1;
                        alufunc  = {1'b0, op[2:0]};
                    end
                    is_lw, is_sw: begin
                        alusel1  = 1'b1;
                        alusel2  = 1'b1;
                        aluen    = 1'b1;
                        ldaluout = 1'b1;
                        alufunc  = ADD_FUNC;
                    end
                    is_bc: begin
                        alusel2  = 1'b1;
                        aluen    = 1'b1;
                        ldaluout = 1'b1;
                        alufunc  = ADD_FUNC;
                        opcond   = cond;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                unique case (1'b1)
                    is_lw: begin
                        readdmem = 1'b1;
                        ldlmd    = 1'b1;
                        state_n  = S_WB;
                    end
                    is_sw: begin
                        writedmem = 1'b1;
                        ldpc      = 1'b1;
                    end
                    is_bc: begin
                        opcond = cond;
                        ldpc   = 1'b1;
                    end
                    is_br: begin
                        branch = 1'b1;
                        ldpc   = 1'b1;
                    end
                    default: state_n = S_WB;
                endcase
                if (ldpc) state_n = run ? S_IF : S_IDLE;
            end
            S_WB: begin
                regwrite = 1'b1;
                selwb    = !is_lw;
                ldpc     = 1'b1;
                state_n  = run ? S_IF : S_IDLE;
            end
            S_HALT: halted = 1'b1;
            S_ERR:  illegal = 1'b1;
            default: state_n = S_IDLE;
        endcase
    end

`ifdef CTRL_PERF_EN
    // Counts on the ldpc edge, so it reflects instructions actually retired.
    logic [31:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     cnt <= 32'h0;
        else if (ldpc) cnt <= cnt + 32'h1;
    end
    assign instret = cnt;
`else
    assign instret = 32'h0;
`endif

endmodule

// File: tb/tb_kgp_control_unit.sv
// Randomized bench for kgp_control_unit against a per-instruction cycle table model.
// Expected instret follows CTRL_PERF_EN if the bench is built with it.
module tb_kgp_control_unit;

    logic        clk, reset, run;
    logic [31:0] ir;
    logic        readim, ldir, ldnpc, ldA, ldB, ldimm;
    logic [1:0]  opcond;
    logic        alusel1, alusel2, aluen, ldaluout;
    logic [3:0]  alufunc;
    logic        regwrite, writedmem, readdmem, ldlmd, selwb, branch, ldpc;
    logic        halted, illegal;
    logic [31:0] instret;

    kgp_control_unit dut (
        .clk(clk), .reset(reset), .run(run), .ir(ir),
        .readim(readim), .ldir(ldir), .ldnpc(ldnpc),
        .ldA(ldA), .ldB(ldB), .ldimm(ldimm),
        .opcond(opcond), .alusel1(alusel1), .alusel2(alusel2),
        .aluen(aluen), .ldaluout(ldaluout), .alufunc(alufunc),
        .regwrite(regwrite), .writedmem(writedmem),
        .readdmem(readdmem), .ldlmd(ldlmd), .selwb(selwb),
        .branch(branch), .ldpc(ldpc), .halted(halted),
        .illegal(illegal), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic readim, ldir, ldnpc, ldA, ldB, ldimm;
        logic [1:0] opcond;
        logic alusel1, alusel2, aluen, ldaluout;
        logic [3:0] alufunc;
        logic regwrite, writedmem, readdmem, ldlmd, selwb, branch, ldpc;
        logic halted, illegal;
    } ctl_t;

    int   total = 0;
    int   bad = 0;
    int   retired = 0;
    ctl_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] obs();
        ctl_t c;
        c = '{readim, ldir, ldnpc, ldA, ldB, ldimm, opcond,
              alusel1, alusel2, aluen, ldaluout, alufunc,
              regwrite, writedmem, readdmem, ldlmd, selwb, branch, ldpc,
              halted, illegal};
        return {7'b0, c};
    endfunction

    function automatic logic [31:0] v(input ctl_t c);
        return {7'b0, c};
    endfunction

    function automatic logic [31:0] want_instret();
`ifdef CTRL_PERF_EN
        return 32'(retired);
`else
        return 32'h0;
`endif
    endfunction

    // Builds the expected ID..last-cycle table; returns 0 retire, 1 halt, 2 illegal.
    function automatic int model(input logic [31:0] i);
        ctl_t c;
        logic [5:0] op;
        int cls;
        op = i[31:26];
        exp_q.delete();
        c = '0;
        c.ldA = 1; c.ldB = 1; c.ldimm = 1;
        exp_q.push_back(c);
        if (op == 6'h3F) return 1;
        if (op == 6'h00)             cls = 0;
        else if (op[5:3] == 3'b001)  cls = 1;
        else if (op == 6'h10)        cls = 2;
        else if (op == 6'h11)        cls = 3;
        else if (op == 6'h20)        cls = 4;
        else if (op inside {6'h21, 6'h22, 6'h23}) cls = 5;
        else return 2;
        c = '0;
        case (cls)
            0: begin
                c.alusel1 = 1; c.aluen = 1; c.ldaluout = 1;
                c.alufunc = i[3:0];
            end
            1: begin
                c.alusel1 = 1; c.alusel2 = 1; c.aluen = 1; c.ldaluout = 1;
                c.alufunc = {1'b0, op[2:0]};
            end
            2, 3: begin
                c.alusel1 = 1; c.alusel2 = 1; c.aluen = 1; c.ldaluout = 1;
            end
            5: begin
                c.alusel2 = 1; c.aluen = 1; c.ldaluout = 1;
                c.opcond = op[1:0];
            end
            default: ;
        endcase
        exp_q.push_back(c);
        c = '0;
        case (cls)
            2: begin c.readdmem = 1; c.ldlmd = 1; end
            3: begin c.writedmem = 1; c.ldpc = 1; end
            4: begin c.branch = 1; c.ldpc = 1; end
            5: begin c.opcond = op[1:0]; c.ldpc = 1; end
            default: ;
        endcase
        exp_q.push_back(c);
        if (cls <= 2) begin
            c = '0;
            c.regwrite = 1; c.ldpc = 1; c.selwb = (cls != 2);
            exp_q.push_back(c);
        end
        return 0;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 7);
        case (k)
            0: r[31:26] = 6'h00;
            1: r[31:29] = 3'b001;
            2: r[31:26] = 6'h10;
            3: r[31:26] = 6'h11;
            4: r[31:26] = 6'h20;
            default: r[31:26] = 6'(6'h21 + k - 5);
        endcase
        return r;
    endfunction

    // Entered with the DUT in IF, one time unit after the clock edge.
    task automatic do_instr(input logic [31:0] instr);
        int kind;
        logic nr;
        ctl_t c;
        c = '0;
        c.readim = 1; c.ldir = 1; c.ldnpc = 1;
        ir = $urandom;
        run = 1'($urandom_range(0, 1));
        check("if", obs(), v(c));
        @(posedge clk); #1;
        ir = instr;
        kind = model(instr);
        nr = ($urandom_range(0, 3) != 0);
        foreach (exp_q[k]) begin
            if (kind == 0 && k == exp_q.size() - 1) run = nr;
            else run = 1'($urandom_range(0, 1));
            check($sformatf("cyc%0d_%h", k + 1, instr), obs(), v(exp_q[k]));
            @(posedge clk); #1;
        end
        if (kind == 0) begin
            retired++;
            check("instret", instret, want_instret());
            if (!nr) begin
                check("idle", obs(), 32'h0);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                    check("idle_wait", obs(), 32'h0);
                end
                run = 1'b1;
                @(posedge clk); #1;
            end
        end else begin
            c = '0;
            if (kind == 1) c.halted = 1;
            else c.illegal = 1;
            repeat (20) begin
                run = 1'($urandom_range(0, 1));
                ir = $urandom;
                check(kind == 1 ? "halt" : "err", obs(), v(c));
                @(posedge clk); #1;
            end
            check("instret_stop", instret, want_instret());
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        retired = 0;
        check("rst_out", obs(), 32'h0);
        check("rst_instret", instret, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        run = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        run = 1'b0;
        ir = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("por_out", obs(), 32'h0);
        check("por_instret", instret, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_hold", obs(), 32'h0);
        run = 1'b1;
        @(posedge clk); #1;

        do_instr(32'h00221803);
        do_instr(32'h40220004);
        do_instr(32'h44220004);
        do_instr(32'h84200010);
        do_instr(32'h80000010);
        do_instr(32'h88200010);
        do_instr(32'h8C200010);
        do_instr(32'h2C220005);
        repeat (40) do_instr(rnd_instr());

        // Abandon an instruction in EX via asynchronous reset.
        ir = $urandom;
        @(posedge clk); #1;
        ir = 32'h00221803;
        @(posedge clk); #1;
        check("ex_alufunc", 32'(alufunc), 32'h3);
        reset = 1'b1;
        #1;
        retired = 0;
        check("midex_out", obs(), 32'h0);
        check("midex_instret", instret, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        run = 1'b0;
        @(posedge clk); #1;
        check("midex_idle", obs(), 32'h0);
        run = 1'b1;
        @(posedge clk); #1;

        do_instr(32'h00221803);
        do_instr(32'h40220004);
        do_instr(32'h44220004);
        do_instr(32'h84200010);
        do_instr(32'h80000010);
        do_instr(rnd_instr());
        do_instr(rnd_instr());
        check("instret7", instret, want_instret());

        do_instr(32'hFC000000);
        do_reset();
        do_instr(32'h14000000);
        do_reset();
        do_instr(32'h00221803);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
